async_frame_receiver: RTL
=========================

ASYNC_FRAME_RECEIVER -- requirements
Module: async_frame_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; must be even and >= 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: message FIFO entries; must be a power of 2.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 20: idle bit-times allowed between bytes of one message.
REQ-004 SHALL have port clk  input  1  sole clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port RxD  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port command  output  8  command byte of the FIFO head message.
REQ-008 SHALL have port data  output  64  data word of the FIFO head message.
REQ-009 SHALL have port valid  output  1  FIFO not empty.
REQ-010 SHALL have port rd_en  input  1  pop the head message.
REQ-011 SHALL have port raw_byte  output  8  last correctly framed byte.
REQ-012 SHALL have port raw_byte_write  output  1  one-cycle pulse per correctly framed byte.
REQ-013 SHALL have port frame_error  output  1  one-cycle pulse on a bad stop or parity bit.
REQ-014 SHALL have port overflow  output  1  sticky flag: a message was dropped because the FIFO was full.

Function
REQ-015 SHALL pass RxD through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-016 SHALL use bit states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-017 SHALL leave IDLE on a synchronized falling edge; in START, sample at CLKS_PER_BIT/2; if high, treat as a glitch and return to IDLE with no output.
REQ-018 SHALL sample 8 data bits, LSB first, one every CLKS_PER_BIT cycles from the START mid-point.
REQ-019 SHALL treat a high STOP sample as a good byte: update raw_byte and pulse raw_byte_write on the next cycle.
REQ-020 SHALL treat a low STOP sample as a bad byte: pulse frame_error, discard the partial message, enter WAIT_HIGH, and return to IDLE only after the synchronized line is high.
REQ-021 SHALL frame a message as 9 bytes: byte 0 = command, bytes 1..8 = data[7:0] through data[63:56] (least significant byte first).
REQ-022 SHALL push {command,data} into the FIFO in the cycle after the 9th good stop sample; valid SHALL be high no later than 2 clk after that stop sample.
REQ-023 SHALL, when the byte count is nonzero and the line has been idle for TIMEOUT_BITS*CLKS_PER_BIT cycles, clear the byte count silently, with no flag.
REQ-024 SHALL use a show-ahead FIFO: command/data present the head whenever valid=1; rd_en with valid=1 advances the head at the next edge; rd_en with valid=0 is ignored.
REQ-025 SHALL drop a push into a full FIFO and set overflow; a push coinciding with a pop from a full FIFO SHALL be accepted.
REQ-026 SHALL keep command/data at the last popped value when the FIFO is empty.

Reset
REQ-027 SHALL, while reset=1: valid=0, command=0, data=0, raw_byte=0, raw_byte_write=0, frame_error=0, overflow=0; FIFO empty, state IDLE, byte count 0, synchronizer flops=1.
REQ-028 SHALL discard any byte or message in progress when reset asserts mid-operation; no output pulses occur on reset release.

Configuration
REQ-029 SHALL, with RX_PARITY_EN defined, expect an even-parity bit between bit 7 and the stop bit (PARITY state); a mismatch behaves exactly like a bad stop bit (REQ-020).
REQ-030 SHALL, without RX_PARITY_EN, skip the PARITY state; frames are 10 bits.

Structure
REQ-031 SHALL take from package async_link_pkg: MSG_BYTES=9, the bit-state enum, the 72-bit message struct {command,data}, and the CLKS_PER_BIT default.
REQ-032 SHALL implement the message FIFO as sub-module msg_fifo: synchronous, show-ahead, parameterized depth and width.

Verification (CLKS_PER_BIT=16)
REQ-033 SHALL check: send 0x42 plus 64'h123456789abcdeff -> valid=1, command=0x42, data=64'h123456789abcdeff, 9 raw_byte_write pulses with raw_byte sequence 0x42,0xff,0xde,...
REQ-034 SHALL check: 4-cycle low glitch on an idle line -> no raw_byte_write, no frame_error.
REQ-035 SHALL check: stop bit forced low on byte 3 -> one frame_error pulse, no valid; the next full message is received intact.
REQ-036 SHALL check: 5 messages sent with rd_en=0 -> 4 entries held, overflow=1; pops return messages 1-4 in order.
REQ-037 SHALL check: 4 bytes, then idle beyond the timeout, then a full message -> exactly one message, equal to the second transmission.
REQ-038 SHALL check: reset asserted mid-byte -> all outputs 0; the next message is received correctly; with RX_PARITY_EN defined, a flipped parity bit -> frame_error and the message is dropped.

Source files
------------

// File: rtl/async_link_pkg.sv
// Shared types and constants for the asynchronous serial message link.
package async_link_pkg;

  localparam int MSG_BYTES            = 9;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } bit_state_t;

  typedef struct packed {
    logic [7:0]  command;
    logic [63:0] data;
  } msg_t;

  localparam int MSG_W = $bits(msg_t);

endpackage

// File: rtl/msg_fifo.sv
// Synchronous show-ahead FIFO; when empty, the output holds the last popped entry.
module msg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 72
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             do_push, do_pop, full, empty;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is still accepted then.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == (AW+1)'(DEPTH));
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    drop     = push && !do_push;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    last_d   = do_pop ? mem_q[rd_ptr_q] : last_q;
    valid    = !empty;
    dout     = empty ? last_q : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/async_frame_receiver.sv
// Serial byte receiver assembling 9-byte {command,data} messages into a FIFO.
// Define RX_PARITY_EN to expect an even-parity bit before the stop bit.
module async_frame_receiver
  import async_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RxD,
  output logic [7:0]  command,
  output logic [63:0] data,
  output logic        valid,
  input  logic        rd_en,
  output logic [7:0]  raw_byte,
  output logic        raw_byte_write,
  output logic        frame_error,
  output logic        overflow
);

  localparam int             CW             = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_M1        = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1        = CW'(CLKS_PER_BIT - 1);
  localparam int             TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int             TW             = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TIMEOUT_M1     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]     LAST_BYTE      = 4'(MSG_BYTES - 1);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  bit_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [3:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [55:0]   data_acc_q, data_acc_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]    raw_byte_q, raw_byte_d;
  logic          raw_write_q, raw_write_d;
  logic          frame_err_q, frame_err_d;
  logic          push_q, push_d;
  msg_t          push_msg_q, push_msg_d;
  logic          overflow_q, overflow_d;
  msg_t          head;
  logic          fifo_drop;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_cnt_d  = byte_cnt_q;
    cmd_d       = cmd_q;
    data_acc_d  = data_acc_q;
    idle_cnt_d  = '0;
    raw_byte_d  = raw_byte_q;
    raw_write_d = 1'b0;
    frame_err_d = 1'b0;
    push_d      = 1'b0;
    push_msg_d  = push_msg_q;
    overflow_d  = overflow_q | fifo_drop;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A stalled partial message is forgotten once the line has idled long enough.
        if (byte_cnt_q != '0) begin
          idle_cnt_d = idle_cnt_q + TW'(1);
          if (idle_cnt_q == TIMEOUT_M1) begin
            byte_cnt_d = '0;
            idle_cnt_d = '0;
          end
        end
        if (rx_prev_q && !rx_sync_q) state_d = START;
      end

      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_sync_q ? IDLE : DATA;
        end
      end

      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
`ifdef RX_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = PARITY;
`else
          if (bit_idx_q == 3'd7) state_d = STOP;
`endif
        end
      end

`ifdef RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_sync_q != ^shift_q) begin
            frame_err_d = 1'b1;
            byte_cnt_d  = '0;
            state_d     = WAIT_HIGH;
          end else begin
            state_d = STOP;
          end
        end
      end
`endif

      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            state_d     = IDLE;
            raw_byte_d  = shift_q;
            raw_write_d = 1'b1;
            // Byte 0 is the command; data bytes arrive least significant first.
            if (byte_cnt_q == '0) begin
              cmd_d      = shift_q;
              byte_cnt_d = 4'd1;
            end else if (byte_cnt_q == LAST_BYTE) begin
              push_d     = 1'b1;
              push_msg_d = {cmd_q, shift_q, data_acc_q};
              byte_cnt_d = '0;
            end else begin
              data_acc_d = {shift_q, data_acc_q[55:8]};
              byte_cnt_d = byte_cnt_q + 4'd1;
            end
          end else begin
            frame_err_d = 1'b1;
            byte_cnt_d  = '0;
            state_d     = WAIT_HIGH;
          end
        end
      end

      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_sync_q) state_d = IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      byte_cnt_q  <= '0;
      cmd_q       <= '0;
      data_acc_q  <= '0;
      idle_cnt_q  <= '0;
      raw_byte_q  <= '0;
      raw_write_q <= 1'b0;
      frame_err_q <= 1'b0;
      push_q      <= 1'b0;
      push_msg_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      rx_meta_q   <= RxD;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      byte_cnt_q  <= byte_cnt_d;
      cmd_q       <= cmd_d;
      data_acc_q  <= data_acc_d;
      idle_cnt_q  <= idle_cnt_d;
      raw_byte_q  <= raw_byte_d;
      raw_write_q <= raw_write_d;
      frame_err_q <= frame_err_d;
      push_q      <= push_d;
      push_msg_q  <= push_msg_d;
      overflow_q  <= overflow_d;
    end
  end

  msg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (MSG_W)
  ) u_msg_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_q),
    .din   (push_msg_q),
    .pop   (rd_en),
    .dout  (head),
    .valid (valid),
    .drop  (fifo_drop)
  );

  assign command        = head.command;
  assign data           = head.data;
  assign raw_byte       = raw_byte_q;
  assign raw_byte_write = raw_write_q;
  assign frame_error    = frame_err_q;
  assign overflow       = overflow_q;

endmodule
